// File: rtl/dff_bank_arbiter.sv
// Round-robin sequencer that time-shares one DATA_W-bit register bank among N_REQ requesters.
// Each service is: grant, load the winner's lane with an ack pulse, hold for HOLD_CYCLES, release.
module dff_bank_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DATA_W-1:0]    data_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           ack_o,
  output logic [$clog2(N_REQ)-1:0]   owner_o,
  output logic [DATA_W-1:0]          q_o,
  output logic                       busy_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    ptr, ptr_next;
  logic [IDX_W-1:0]    owner_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [N_REQ-1:0]    gnt_next, ack_next;
  logic [DATA_W-1:0]   q_next;
  logic                busy_next;

  logic [IDX_W-1:0]    win_hi, win_lo, winner;
  logic                found_hi;
  logic [N_REQ-1:0]    winner_onehot, owner_onehot;
  logic [DATA_W-1:0]   lane_sel;

  // Rotating priority: indices above the last owner first, then wrap to the lowest index.
  // Descending loops let the lowest qualifying index win in each half.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k] && (IDX_W'(k) > ptr)) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(k);
      end
      if (req_i[k]) begin
        win_lo = IDX_W'(k);
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    winner_onehot = '0;
    owner_onehot  = '0;
    lane_sel      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      winner_onehot[k] = (winner == IDX_W'(k));
      owner_onehot[k]  = (owner_o == IDX_W'(k));
      if (owner_o == IDX_W'(k)) begin
        lane_sel = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    gnt_next   = gnt_o;
    ack_next   = '0;
    owner_next = owner_o;
    q_next     = q_o;

    case (state)
      IDLE: begin
        if (ena && (|req_i)) begin
          state_next = GRANT;
          gnt_next   = winner_onehot;
          owner_next = winner;
        end
      end
      GRANT: begin
        q_next   = lane_sel;
        ack_next = owner_onehot;
        ptr_next = owner_o;
        if (HOLD_CYCLES == 0) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else begin
          state_next = HOLD;
          cnt_next   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // Every output is a flop so the tile's uo_out drive sees clean registered values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= PTR_RST;
      cnt     <= '0;
      gnt_o   <= '0;
      ack_o   <= '0;
      owner_o <= '0;
      q_o     <= '0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      cnt     <= cnt_next;
      gnt_o   <= gnt_next;
      ack_o   <= ack_next;
      owner_o <= owner_next;
      q_o     <= q_next;
      busy_o  <= busy_next;
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack_o));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_o));
  a_ack_single: assert property (@(posedge clk) disable iff (rst) (|ack_o) |=> (ack_o == '0));

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: a vector table for reset/single-service/ena behaviour,
// then hand-written round-robin and reset-during-hold sequences.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  ack_o;
  logic [1:0]  owner_o;
  logic [7:0]  q_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  dff_bank_arbiter #(
    .N_REQ(4),
    .DATA_W(8),
    .HOLD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .req_i(req_i),
    .data_i(data_i),
    .gnt_o(gnt_o),
    .ack_o(ack_o),
    .owner_o(owner_o),
    .q_o(q_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  own;
    logic [7:0]  q;
    logic        busy;
    string       name;
  } vec_t;

  localparam logic [31:0] D_A5 = 32'h00A5_0000;
  localparam logic [31:0] D_77 = 32'h00A5_0077;
  localparam logic [31:0] D_RR = 32'h4433_2211;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] gnt, input logic [3:0] ack,
                             input logic [1:0] own, input logic [7:0] q, input logic busy);
    n_checks++;
    if (gnt_o !== gnt || ack_o !== ack || owner_o !== own || q_o !== q || busy_o !== busy) begin
      n_fail++;
      $display("[TB] FAIL %s: got gnt=%b ack=%b owner=%0d q=%h busy=%b, expected gnt=%b ack=%b owner=%0d q=%h busy=%b",
               name, gnt_o, ack_o, owner_o, q_o, busy_o, gnt, ack, own, q, busy);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst    = v.rst;
    ena    = v.ena;
    req_i  = v.req;
    data_i = v.data;
    tick();
    checkOutput(v.name, v.gnt, v.ack, v.own, v.q, v.busy);
  endtask

  // One full service with HOLD_CYCLES=2: grant, ack+load, hold, idle.
  task automatic serve(input int owner, input logic [7:0] new_q, input logic [7:0] old_q, input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << owner;
    tick();
    checkOutput($sformatf("svc%0d_gnt", idx), oh, 4'b0000, 2'(owner), old_q, 1'b1);
    tick();
    checkOutput($sformatf("svc%0d_ack", idx), oh, oh, 2'(owner), new_q, 1'b1);
    tick();
    checkOutput($sformatf("svc%0d_hold", idx), oh, 4'b0000, 2'(owner), new_q, 1'b1);
    tick();
    checkOutput($sformatf("svc%0d_idle", idx), 4'b0000, 4'b0000, 2'(owner), new_q, 1'b0);
  endtask

  initial begin
    int          rr_owner[10];
    logic [7:0]  lane[4];
    logic [7:0]  prev_q;

    rst    = 1'b1;
    ena    = 1'b0;
    req_i  = 4'b0000;
    data_i = '0;

    vecs[0]  = '{1'b1, 1'b1, 4'b1011, D_A5, 4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0, "reset_a"};
    vecs[1]  = '{1'b1, 1'b0, 4'b0110, D_A5, 4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0, "reset_b"};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, D_A5, 4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0, "released_idle"};
    vecs[3]  = '{1'b0, 1'b1, 4'b0100, D_A5, 4'b0100, 4'b0000, 2'd2, 8'h00, 1'b1, "a5_grant"};
    vecs[4]  = '{1'b0, 1'b1, 4'b0100, D_A5, 4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1, "a5_ack"};
    vecs[5]  = '{1'b0, 1'b1, 4'b0000, D_A5, 4'b0100, 4'b0000, 2'd2, 8'hA5, 1'b1, "a5_hold"};
    vecs[6]  = '{1'b0, 1'b1, 4'b0000, D_A5, 4'b0000, 4'b0000, 2'd2, 8'hA5, 1'b0, "a5_idle"};
    for (int i = 7; i < 12; i++)
      vecs[i] = '{1'b0, 1'b0, 4'b0001, D_77, 4'b0000, 4'b0000, 2'd2, 8'hA5, 1'b0, $sformatf("ena_off%0d", i - 7)};
    vecs[12] = '{1'b0, 1'b1, 4'b0001, D_77, 4'b0001, 4'b0000, 2'd0, 8'hA5, 1'b1, "ena_on_grant"};
    vecs[13] = '{1'b0, 1'b0, 4'b0001, D_77, 4'b0001, 4'b0001, 2'd0, 8'h77, 1'b1, "ena_drop_ack"};
    vecs[14] = '{1'b0, 1'b0, 4'b0000, D_77, 4'b0001, 4'b0000, 2'd0, 8'h77, 1'b1, "ena_drop_hold"};
    vecs[15] = '{1'b0, 1'b0, 4'b0000, D_77, 4'b0000, 4'b0000, 2'd0, 8'h77, 1'b0, "ena_drop_idle"};
    vecs[16] = '{1'b1, 1'b0, 4'b0000, D_77, 4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0, "reset_c"};

    $display("[TB] table vectors");
    for (int i = 0; i < 17; i++) applyStimulus(vecs[i]);

    $display("[TB] round-robin with all requesters, then 4'b1101");
    lane[0] = 8'h11; lane[1] = 8'h22; lane[2] = 8'h33; lane[3] = 8'h44;
    rr_owner[0] = 0; rr_owner[1] = 1; rr_owner[2] = 2; rr_owner[3] = 3; rr_owner[4] = 0;
    rr_owner[5] = 1; rr_owner[6] = 2; rr_owner[7] = 3; rr_owner[8] = 0; rr_owner[9] = 2;
    rst    = 1'b0;
    ena    = 1'b1;
    data_i = D_RR;
    req_i  = 4'b1111;
    prev_q = 8'h00;
    for (int s = 0; s < 10; s++) begin
      if (s == 7) req_i = 4'b1101;
      serve(rr_owner[s], lane[rr_owner[s]], prev_q, s);
      prev_q = lane[rr_owner[s]];
    end

    req_i = 4'b0000;
    tick();
    checkOutput("rr_quiet", 4'b0000, 4'b0000, 2'd2, 8'h33, 1'b0);

    $display("[TB] reset during hold");
    req_i = 4'b1000;
    tick();
    checkOutput("hr_grant", 4'b1000, 4'b0000, 2'd3, 8'h33, 1'b1);
    tick();
    checkOutput("hr_ack", 4'b1000, 4'b1000, 2'd3, 8'h44, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("hr_reset", 4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0);
    rst   = 1'b0;
    req_i = 4'b1001;
    tick();
    checkOutput("hr_regrant", 4'b0001, 4'b0000, 2'd0, 8'h00, 1'b1);
    req_i = 4'b0000;
    tick();
    checkOutput("hr_reack", 4'b0001, 4'b0001, 2'd0, 8'h11, 1'b1);
    tick();
    checkOutput("hr_hold", 4'b0001, 4'b0000, 2'd0, 8'h11, 1'b1);
    tick();
    checkOutput("hr_idle", 4'b0000, 4'b0000, 2'd0, 8'h11, 1'b0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
